// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and flag indices shared by the multi-cycle ALU
package alu_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_ST   = 5'd1;
    localparam logic [4:0] OP_LIL  = 5'd2;
    localparam logic [4:0] OP_MOV  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_CMP  = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_XOR  = 5'd9;
    localparam logic [4:0] OP_NEG  = 5'd10;
    localparam logic [4:0] OP_NOT  = 5'd11;
    localparam logic [4:0] OP_SLL  = 5'd12;
    localparam logic [4:0] OP_SLA  = 5'd13;
    localparam logic [4:0] OP_SRL  = 5'd14;
    localparam logic [4:0] OP_SRA  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17;
    localparam logic [4:0] OP_REMU = 5'd18;
    localparam logic [4:0] OP_NOP  = 5'd19;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    // Ops that run on the shared iterative engine instead of the one-cycle datapath
    function automatic logic is_iter(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - request/result handshake bundle between control unit and ALU
interface alu_mc_if #(
    parameter int W    = 32,
    parameter int IMMW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic            use_imm;
    logic [W-1:0]    sr;
    logic [W-1:0]    tr;
    logic [IMMW-1:0] imm;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    dr;
    logic [3:0]      flags;
    logic            dz;
    logic            busy;

    modport master (
        output in_valid, op, use_imm, sr, tr, imm, out_ready,
        input  in_ready, out_valid, dr, flags, dz, busy
    );

    modport slave (
        input  in_valid, op, use_imm, sr, tr, imm, out_ready,
        output in_ready, out_valid, dr, flags, dz, busy
    );
endinterface

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - shared shift-add multiply / restoring divide engine, one bit per cycle
module alu_iter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi
);
    localparam int CW = $clog2(W + 1);

    // hi holds the upper product half or the partial remainder;
    // lo holds the multiplier being consumed or the dividend/quotient shift register.
    logic [CW-1:0] cnt_q;
    logic          div_q;
    logic [W-1:0]  hi_q, lo_q, b_q;
    logic [W-1:0]  hi_d, lo_d;
    logic [W:0]    sum;
    logic [W:0]    shifted;

    // One iteration of either algorithm; the caller samples res_* on the done cycle
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        shifted = {hi_q, lo_q[W-1]};
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (div_q) begin
            if (shifted >= {1'b0, b_q}) begin
                hi_d = W'(shifted - {1'b0, b_q});
                lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
                hi_d = shifted[W-1:0];
                lo_d = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[W:1];
            lo_d = {sum[0], lo_q[W-1:1]};
        end
    end

    assign done   = (cnt_q == CW'(1));
    assign res_lo = lo_d;
    assign res_hi = hi_d;

    // Load operands on start, then iterate until the counter runs out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
        end else if (start) begin
            cnt_q <= CW'(W);
            div_q <= is_div;
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered multi-cycle ALU with valid/ready handshake
module alu_mc
    import alu_pkg::*;
#(
    parameter int W    = 32,
    parameter int IMMW = 8,
    parameter int SHW  = $clog2(W) + 1
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_mc_if.slave bus
);
    state_t         state_q, state_d;
    logic           in_ready, accept, iter_op;
    logic           out_valid_q, dz_q, div0_q;
    logic [W-1:0]   dr_q;
    logic [3:0]     flags_q;
    logic [4:0]     calc_op_q;

    logic [W-1:0]   opb;
    logic [W:0]     add_r, sub_r, neg_r, sl, sr_w, sra_w;
    logic           add_v, sub_v, neg_v, sh_big;
    logic [SHW-1:0] amt;

    logic [W-1:0]   res;
    logic           c, v, wr_dr, wr_fl;
    logic [3:0]     fl;

    logic           it_done;
    logic [W-1:0]   res_lo, res_hi, iter_res;
    logic [3:0]     iter_fl;
    logic           iter_dz;

    // DONE only differs from IDLE in that it marks a freshly finished iteration
    assign in_ready = (state_q != CALC) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign iter_op  = is_iter(bus.op);

    assign opb    = bus.use_imm ? W'(bus.imm) : bus.sr;
    assign add_r  = {1'b0, bus.tr} + {1'b0, opb};
    assign sub_r  = {1'b0, bus.tr} - {1'b0, opb};
    assign neg_r  = {(W+1){1'b0}} - {1'b0, bus.tr};
    assign add_v  = (bus.tr[W-1] == opb[W-1]) && (add_r[W-1] != bus.tr[W-1]);
    assign sub_v  = (bus.tr[W-1] != opb[W-1]) && (sub_r[W-1] != bus.tr[W-1]);
    assign neg_v  = bus.tr[W-1] && neg_r[W-1];

    // Shifts run one bit wider so the last bit shifted out lands in the extra bit
    assign amt    = opb[SHW-1:0];
    assign sh_big = (amt >= SHW'(W));
    assign sl     = {1'b0, bus.tr} << amt;
    assign sr_w   = {bus.tr, 1'b0} >> amt;
    assign sra_w  = $signed({bus.tr, 1'b0}) >>> amt;

    // One-cycle datapath: result, flags and which of them the op is allowed to write
    always_comb begin
        res   = '0;
        c     = 1'b0;
        v     = 1'b0;
        wr_dr = 1'b1;
        wr_fl = 1'b1;
        fl    = '0;
        case (bus.op)
            OP_LD, OP_ST, OP_ADD: begin res = add_r[W-1:0]; c = add_r[W]; v = add_v; end
            OP_LIL:  res = W'(16'({bus.sr, bus.imm}));
            OP_MOV:  res = opb;
            OP_SUB:  begin res = sub_r[W-1:0]; c = sub_r[W]; v = sub_v; end
            OP_CMP:  begin res = sub_r[W-1:0]; c = sub_r[W]; v = sub_v; wr_dr = 1'b0; end
            OP_AND:  res = bus.tr & opb;
            OP_OR:   res = bus.tr | opb;
            OP_XOR:  res = bus.tr ^ opb;
            OP_NEG:  begin res = neg_r[W-1:0]; c = neg_r[W]; v = neg_v; end
            OP_NOT:  res = ~bus.tr;
            OP_SLL, OP_SLA: begin
                res = sh_big ? '0 : sl[W-1:0];
                c   = !sh_big && sl[W];
            end
            OP_SRL: begin
                res = sh_big ? '0 : sr_w[W:1];
                c   = !sh_big && sr_w[0];
            end
            OP_SRA: begin
                res = sh_big ? {W{bus.tr[W-1]}} : sra_w[W:1];
                c   = !sh_big && sra_w[0];
            end
            OP_NOP:  begin wr_dr = 1'b0; wr_fl = 1'b0; end
            default: ;
        endcase
        // Reserved codes fall through with res = 0 but must report all-clear flags
        if (!iter_op && (bus.op > OP_NOP)) begin
            fl = '0;
        end else begin
            fl[FZ] = (res == '0);
            fl[FN] = res[W-1];
            fl[FC] = c;
            fl[FV] = v;
        end
    end

    alu_iter #(.W(W)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && iter_op),
        .is_div (bus.op != OP_MUL),
        .a      (bus.tr),
        .b      (opb),
        .done   (it_done),
        .res_lo (res_lo),
        .res_hi (res_hi)
    );

    // Final value of an iterative op; a zero divisor is flagged through dz and V
    always_comb begin
        iter_res    = (calc_op_q == OP_REMU) ? res_hi : res_lo;
        iter_dz     = (calc_op_q != OP_MUL) && div0_q;
        iter_fl     = '0;
        iter_fl[FZ] = (iter_res == '0);
        iter_fl[FN] = iter_res[W-1];
        iter_fl[FC] = (calc_op_q == OP_MUL) && (res_hi != '0);
        iter_fl[FV] = iter_dz;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: accepts from IDLE or DONE, CALC leaves on the last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = iter_op ? CALC : IDLE;
            end
            CALC: begin
                if (it_done) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers: written on a one-cycle accept or the last iteration, else drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dr_q        <= '0;
            flags_q     <= '0;
            dz_q        <= 1'b0;
            calc_op_q   <= OP_NOP;
            div0_q      <= 1'b0;
        end else begin
            if (accept && !iter_op) begin
                if (wr_dr) dr_q <= res;
                if (wr_fl) flags_q <= fl;
                dz_q        <= 1'b0;
                out_valid_q <= 1'b1;
            end else if ((state_q == CALC) && it_done) begin
                dr_q        <= iter_res;
                flags_q     <= iter_fl;
                dz_q        <= iter_dz;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && iter_op) begin
                calc_op_q <= bus.op;
                div0_q    <= (opb == '0);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.dr        = dr_q;
    assign bus.flags     = flags_q;
    assign bus.dz        = dz_q;
    assign bus.busy      = (state_q == CALC);
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc at W=32 and W=16
module tb_alu_mc;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   errors;

    alu_mc_if #(.W(32), .IMMW(8)) b32 ();
    alu_mc_if #(.W(16), .IMMW(8)) b16 ();

    alu_mc #(.W(32), .IMMW(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    alu_mc #(.W(16), .IMMW(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send32(input logic [4:0] o, input logic ui, input logic [31:0] s,
                          input logic [31:0] t, input logic [7:0] i);
        int n;
        n = 0;
        @(negedge clk);
        b32.op = o; b32.use_imm = ui; b32.sr = s; b32.tr = t; b32.imm = i;
        b32.in_valid = 1'b1;
        #1;
        while (b32.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (b32.in_ready !== 1'b1) begin
            tests++; errors++;
            $display("FAIL send32_timeout in_ready=%b required 1", b32.in_ready);
        end
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
    endtask

    task automatic send16(input logic [4:0] o, input logic [15:0] t, input logic [7:0] i);
        int n;
        n = 0;
        @(negedge clk);
        b16.op = o; b16.use_imm = 1'b1; b16.sr = '0; b16.tr = t; b16.imm = i;
        b16.in_valid = 1'b1;
        #1;
        while (b16.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (b16.in_ready !== 1'b1) begin
            tests++; errors++;
            $display("FAIL send16_timeout in_ready=%b required 1", b16.in_ready);
        end
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (b32.out_valid !== 1'b0 || b32.busy !== 1'b0 || b32.dz !== 1'b0) begin
            errors++;
            $display("FAIL reset32_ctrl got v=%b b=%b dz=%b required 0 0 0", b32.out_valid, b32.busy, b32.dz);
        end
        tests++;
        if (b32.dr !== 32'h0 || b32.flags !== 4'h0) begin
            errors++;
            $display("FAIL reset32_data got dr=%h fl=%b required 0 0000", b32.dr, b32.flags);
        end
        tests++;
        if (b16.out_valid !== 1'b0 || b16.dr !== 16'h0 || b16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset16 got v=%b dr=%h rdy=%b required 0 0 1", b16.out_valid, b16.dr, b16.in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub;
        send32(OP_ADD, 1'b1, 32'h0, 32'hFFFF_FFFF, 8'd1);
        @(negedge clk);
        tests++;
        if (b32.out_valid !== 1'b1 || b32.dr !== 32'h0 || b32.flags !== 4'b1010) begin
            errors++;
            $display("FAIL add_wrap got v=%b dr=%h fl=%b required 1 00000000 1010", b32.out_valid, b32.dr, b32.flags);
        end
        send32(OP_SUB, 1'b1, 32'h0, 32'h8000_0000, 8'd1);
        @(negedge clk);
        tests++;
        if (b32.out_valid !== 1'b1 || b32.dr !== 32'h7FFF_FFFF || b32.flags !== 4'b0001) begin
            errors++;
            $display("FAIL sub_ovf got v=%b dr=%h fl=%b required 1 7fffffff 0001", b32.out_valid, b32.dr, b32.flags);
        end
    endtask

    task automatic test_cmp_misc;
        send32(OP_CMP, 1'b1, 32'h0, 32'd5, 8'd7);
        @(negedge clk);
        tests++;
        if (b32.dr !== 32'h7FFF_FFFF || b32.flags !== 4'b0110) begin
            errors++;
            $display("FAIL cmp got dr=%h fl=%b required 7fffffff 0110", b32.dr, b32.flags);
        end
        send32(OP_NOP, 1'b0, 32'h55, 32'h66, 8'd0);
        @(negedge clk);
        tests++;
        if (b32.out_valid !== 1'b1 || b32.dr !== 32'h7FFF_FFFF || b32.flags !== 4'b0110) begin
            errors++;
            $display("FAIL nop got v=%b dr=%h fl=%b required 1 7fffffff 0110", b32.out_valid, b32.dr, b32.flags);
        end
        send32(OP_NEG, 1'b0, 32'h0, 32'd1, 8'd0);
        @(negedge clk);
        tests++;
        if (b32.dr !== 32'hFFFF_FFFF || b32.flags !== 4'b0110) begin
            errors++;
            $display("FAIL neg got dr=%h fl=%b required ffffffff 0110", b32.dr, b32.flags);
        end
        send32(OP_LIL, 1'b0, 32'hAB, 32'h0, 8'hCD);
        @(negedge clk);
        tests++;
        if (b32.dr !== 32'h0000_ABCD || b32.flags !== 4'b0000) begin
            errors++;
            $display("FAIL lil got dr=%h fl=%b required 0000abcd 0000", b32.dr, b32.flags);
        end
        send32(5'd31, 1'b0, 32'h1, 32'h2, 8'd3);
        @(negedge clk);
        tests++;
        if (b32.out_valid !== 1'b1 || b32.dr !== 32'h0 || b32.flags !== 4'b0000 || b32.dz !== 1'b0) begin
            errors++;
            $display("FAIL reserved got v=%b dr=%h fl=%b dz=%b required 1 0 0000 0", b32.out_valid, b32.dr, b32.flags, b32.dz);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        @(negedge clk);
        b32.out_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                tests++;
                if (b32.out_valid !== 1'b1 || b32.dr !== 32'(2 * (i - 1))) begin
                    errors++;
                    $display("FAIL b2b_result%0d got v=%b dr=%h required 1 %h", i - 1, b32.out_valid, b32.dr, 32'(2 * (i - 1)));
                end
            end
            if (i < 10) begin
                b32.op = OP_ADD; b32.use_imm = 1'b1; b32.tr = 32'(i); b32.imm = 8'(i);
                b32.in_valid = 1'b1;
                #1;
                tests++;
                if (b32.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready%0d got %b required 1", i, b32.in_ready);
                end
            end else begin
                b32.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        b32.out_ready = 1'b0;
        b32.op = OP_ADD; b32.use_imm = 1'b1; b32.tr = 32'd20; b32.imm = 8'd1;
        b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.tr = 32'd30; b32.imm = 8'd2;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1 || b32.dr !== 32'd21) bad++;
        end
        tests++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold got %0d bad cycles dr=%h required 0 bad cycles dr=00000015", bad, b32.dr);
        end
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (b32.out_valid !== 1'b1 || b32.dr !== 32'd32) begin
            errors++;
            $display("FAIL drain_accept got v=%b dr=%h required 1 00000020", b32.out_valid, b32.dr);
        end
    endtask

    task automatic test_mul;
        int bad;
        int n;
        send32(OP_MUL, 1'b0, 32'h0001_0000, 32'h0001_0000, 8'd0);
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (b32.busy !== 1'b1 || b32.in_ready !== 1'b0 || b32.out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mul_busy_window got %0d bad cycles required 0", bad);
        end
        @(negedge clk);
        tests++;
        if (b32.out_valid !== 1'b1 || b32.dr !== 32'h0 || b32.flags !== 4'b1010 || b32.busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_big got v=%b dr=%h fl=%b busy=%b required 1 0 1010 0", b32.out_valid, b32.dr, b32.flags, b32.busy);
        end
        send32(OP_MUL, 1'b1, 32'h0, 32'hFFFF_FFFF, 8'd2);
        n = 0;
        do begin @(negedge clk); n++; end while (b32.out_valid !== 1'b1 && n < 60);
        tests++;
        if (n != 33 || b32.dr !== 32'hFFFF_FFFE || b32.flags !== 4'b0110) begin
            errors++;
            $display("FAIL mul_neg got lat=%0d dr=%h fl=%b required 33 fffffffe 0110", n, b32.dr, b32.flags);
        end
    endtask

    task automatic test_div;
        logic [4:0]  ops [4]  = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU};
        logic [31:0] trs [4]  = '{32'd100, 32'd100, 32'h1234, 32'h1234};
        logic [31:0] srs [4]  = '{32'd7, 32'd7, 32'd0, 32'd0};
        logic [31:0] exp_dr [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234};
        logic [3:0]  exp_fl [4] = '{4'b0000, 4'b0000, 4'b0101, 4'b0001};
        logic        exp_dz [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int n;
        for (int k = 0; k < 4; k++) begin
            send32(ops[k], 1'b0, srs[k], trs[k], 8'd0);
            n = 0;
            do begin @(negedge clk); n++; end while (b32.out_valid !== 1'b1 && n < 60);
            tests++;
            if (n != 33 || b32.dr !== exp_dr[k] || b32.flags !== exp_fl[k] || b32.dz !== exp_dz[k]) begin
                errors++;
                $display("FAIL div%0d got lat=%0d dr=%h fl=%b dz=%b required 33 %h %b %b",
                         k, n, b32.dr, b32.flags, b32.dz, exp_dr[k], exp_fl[k], exp_dz[k]);
            end
        end
    endtask

    task automatic test_shift32;
        logic [4:0]  ops [3]    = '{OP_SRA, OP_SRL, OP_SLL};
        logic [31:0] trs [3]    = '{32'h8000_0000, 32'hC000_0000, 32'h1234_5678};
        logic [7:0]  amts [3]   = '{8'd40, 8'd31, 8'd0};
        logic [31:0] exp_dr [3] = '{32'hFFFF_FFFF, 32'h1, 32'h1234_5678};
        logic [3:0]  exp_fl [3] = '{4'b0100, 4'b0010, 4'b0000};
        for (int k = 0; k < 3; k++) begin
            send32(ops[k], 1'b1, 32'h0, trs[k], amts[k]);
            @(negedge clk);
            tests++;
            if (b32.dr !== exp_dr[k] || b32.flags !== exp_fl[k]) begin
                errors++;
                $display("FAIL shift32_%0d got dr=%h fl=%b required %h %b", k, b32.dr, b32.flags, exp_dr[k], exp_fl[k]);
            end
        end
    endtask

    task automatic test_shift16;
        logic [4:0]  ops [5]    = '{OP_SRA, OP_SRA, OP_SLL, OP_SLL, OP_SRL};
        logic [15:0] trs [5]    = '{16'h8000, 16'h8000, 16'h0003, 16'h0003, 16'h8001};
        logic [7:0]  amts [5]   = '{8'd15, 8'd16, 8'd15, 8'd16, 8'd16};
        logic [15:0] exp_dr [5] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000, 16'h0000};
        logic [3:0]  exp_fl [5] = '{4'b0100, 4'b0100, 4'b0110, 4'b1000, 4'b1000};
        for (int k = 0; k < 5; k++) begin
            send16(ops[k], trs[k], amts[k]);
            @(negedge clk);
            tests++;
            if (b16.out_valid !== 1'b1 || b16.dr !== exp_dr[k] || b16.flags !== exp_fl[k]) begin
                errors++;
                $display("FAIL shift16_%0d got v=%b dr=%h fl=%b required 1 %h %b",
                         k, b16.out_valid, b16.dr, b16.flags, exp_dr[k], exp_fl[k]);
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        send32(OP_MUL, 1'b0, 32'd3, 32'd5, 8'd0);
        repeat (5) @(negedge clk);
        tests++;
        if (b32.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_mul_busy got %b required 1", b32.busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (b32.out_valid !== 1'b0 || b32.busy !== 1'b0 || b32.dr !== 32'h0) begin
            errors++;
            $display("FAIL mid_mul_reset got v=%b busy=%b dr=%h required 0 0 0", b32.out_valid, b32.busy, b32.dr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send32(OP_ADD, 1'b1, 32'h0, 32'd3, 8'd4);
        @(negedge clk);
        tests++;
        if (b32.out_valid !== 1'b1 || b32.dr !== 32'd7 || b32.flags !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_add got v=%b dr=%h fl=%b required 1 7 0000", b32.out_valid, b32.dr, b32.flags);
        end
        repeat (40) @(negedge clk);
        tests++;
        if (b32.busy !== 1'b0 || b32.dr !== 32'd7) begin
            errors++;
            $display("FAIL no_ghost_mul got busy=%b dr=%h required 0 7", b32.busy, b32.dr);
        end
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        rst_n  = 1'b0;
        b32.in_valid = 1'b0; b32.op = OP_NOP; b32.use_imm = 1'b0;
        b32.sr = '0; b32.tr = '0; b32.imm = '0; b32.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.op = OP_NOP; b16.use_imm = 1'b0;
        b16.sr = '0; b16.tr = '0; b16.imm = '0; b16.out_ready = 1'b1;

        test_reset;
        test_add_sub;
        test_cmp_misc;
        test_back_to_back;
        test_mul;
        test_div;
        test_shift32;
        test_shift16;
        test_reset_mid_mul;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
